// File: rtl/writeback_regfile_if.sv
// Memory-to-writeback bus: memory-stage results and W controls in,
// W register contents, read data and program status back out.
interface writeback_regfile_if;
  logic        W_stall;
  logic        W_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] rvalA;
  logic [63:0] rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [2:0]  prog_stat;
  logic        halted;
  logic [63:0] retired;

  modport master (
    output W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, srcA, srcB,
    input  rvalA, rvalB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, prog_stat, halted, retired
  );

  modport slave (
    input  W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, srcA, srcB,
    output rvalA, rvalB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, prog_stat, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: M/W pipeline register, 15 x 64-bit register file,
// sticky halt latch with terminating status, and retired-instruction counter.
//
// state    | meaning
// ST_RUN   | program running, AOK instructions commit to the register file
// ST_HALT  | non-AOK status reached writeback; W, registers and counter frozen
module writeback_regfile #(
  parameter int REG_COUNT = 15
) (
  input logic               clk,
  input logic               reset,
  writeback_regfile_if.slave wb
);
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        we;
  logic [63:0] regs [REG_COUNT];

  assign wb.halted = (state == ST_HALT);
  assign we        = !wb.halted && (wb.W_stat == STAT_AOK);

  // W pipeline register: hold on stall or halt, bubble ahead of normal load
  always_ff @(posedge clk) begin
    if (reset || (!wb.W_stall && !wb.halted && wb.W_bubble)) begin
      wb.W_stat  <= STAT_AOK;
      wb.W_icode <= I_NOP;
      wb.W_dstE  <= RNONE;
      wb.W_dstM  <= RNONE;
      wb.W_valE  <= '0;
      wb.W_valM  <= '0;
    end else if (!wb.W_stall && !wb.halted) begin
      wb.W_stat  <= wb.m_stat;
      wb.W_icode <= wb.m_icode;
      wb.W_dstE  <= wb.m_dstE;
      wb.W_dstM  <= wb.m_dstM;
      wb.W_valE  <= wb.m_valE;
      wb.W_valM  <= wb.m_valM;
    end
  end

  // Register file write; port M is applied last so it wins on a shared destination
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      if (wb.W_dstE != RNONE) regs[wb.W_dstE] <= wb.W_valE;
      if (wb.W_dstM != RNONE) regs[wb.W_dstM] <= wb.W_valM;
    end
  end

  // Unbypassed reads; decode forwards pending writes from the W outputs
  always_comb begin
    wb.rvalA = '0;
    wb.rvalB = '0;
    if (wb.srcA != RNONE) wb.rvalA = regs[wb.srcA];
    if (wb.srcB != RNONE) wb.rvalB = regs[wb.srcB];
  end

  // Count committed real instructions; NOPs and bubbles do not retire
  always_ff @(posedge clk) begin
    if (reset)                        wb.retired <= '0;
    else if (we && wb.W_icode != I_NOP) wb.retired <= wb.retired + 64'd1;
  end

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Any status other than AOK, including undefined codes, ends the program
  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && wb.W_stat != STAT_AOK) state_nxt = ST_HALT;
  end

  // Capture the terminating status on the run-to-halt transition
  always_ff @(posedge clk) begin
    if (reset)                                     wb.prog_stat <= STAT_AOK;
    else if (state == ST_RUN && state_nxt == ST_HALT) wb.prog_stat <= wb.W_stat;
  end
endmodule
